// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: single-outstanding request bridge from datapath memory port to system bus
// Optional feature: define MEM_BUS_TIMEOUT_EN to abort BUSY accesses after TIMEOUT_CYCLES cycles.
module mem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_done;
    logic        w_timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    assign w_accept  = (r_state == IDLE) && req_valid;
    assign w_done    = (r_state == BUSY) && bus_ready;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_wstrb = r_wstrb;
    assign rsp_rdata = r_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next-state: accept in IDLE, leave BUSY on completion or abort, RESP lasts one cycle
    always_comb begin
        w_next = (r_state == IDLE) ? (req_valid ? BUSY : IDLE) :
                 (r_state == BUSY) ? ((bus_ready || w_timeout) ? RESP : BUSY) : IDLE;
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        req_ready = (r_state == IDLE);
        bus_valid = (r_state == BUSY);
        rsp_valid = (r_state == RESP);
    end

    // Request capture; values stay on the bus until the next accepted request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wstrb <= 4'h0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // Read data: loaded only by completed reads, zeroed by an abort, otherwise held
    always_ff @(posedge clk) begin
        if (reset)
            r_rdata <= 32'h0;
        else if (w_done && (r_wstrb == 4'h0))
            r_rdata <= bus_rdata;
        else if (w_timeout)
            r_rdata <= 32'h0;
    end

`ifdef MEM_BUS_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_err;

    // Abort fires on the BUSY cycle that brings the stalled count to TIMEOUT_CYCLES;
    // a bus_ready on that same cycle wins and completes normally.
    assign w_timeout = (r_state == BUSY) && !bus_ready && (r_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign rsp_err   = r_err && (r_state == RESP);

    // Stall counter and abort flag; the flag reflects the last BUSY cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 16'h0;
            r_err <= 1'b0;
        end else begin
            if (w_accept)
                r_cnt <= 16'h0;
            else if ((r_state == BUSY) && !bus_ready)
                r_cnt <= r_cnt + 16'd1;
            if (r_state == BUSY)
                r_err <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed stimulus with a transaction-level reference model and per-cycle compare
module tb_mem_bus_bridge;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [3:0]  req_wstrb = 4'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int pass_cnt = 0;
    int chk_cnt = 0;
    int bv_total = 0;
    int rsp_total = 0;

    mem_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one access in flight (phase 0 idle, 1 on the bus, 2 responding)
    int          m_phase = 0;
    int          m_age = 0;
    bit          m_init = 0;
    bit          m_err = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [3:0]  m_wstrb = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_age = 0; m_err = 0; m_init = 1;
            m_addr = 0; m_wdata = 0; m_wstrb = 0; m_rdata = 0;
        end else if (m_phase == 0) begin
            if (req_valid) begin
                m_addr = req_addr; m_wdata = req_wdata; m_wstrb = req_wstrb;
                m_age = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_age++;
            if (bus_ready) begin
                if (m_wstrb == 0) m_rdata = bus_rdata;
                m_err = 0; m_phase = 2;
            end
`ifdef MEM_BUS_TIMEOUT_EN
            else if (m_age == TO) begin
                m_rdata = 0; m_err = 1; m_phase = 2;
            end
`endif
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("req_ready", req_ready, m_phase == 0);
            chk("bus_valid", bus_valid, m_phase == 1);
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_wdata", bus_wdata, m_wdata);
            chk("bus_wstrb", bus_wstrb, m_wstrb);
            chk("rsp_valid", rsp_valid, m_phase == 2);
            chk("rsp_err", rsp_err, m_phase == 2 && m_err);
            chk("rsp_rdata", rsp_rdata, m_rdata);
            if (bus_valid) bv_total++;
            if (rsp_valid) rsp_total++;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_wstrb = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic finish_bus(input int waits, input logic [31:0] rd);
        repeat (waits) @(negedge clk);
        bus_ready = 1'b1; bus_rdata = rd;
        @(negedge clk);
        bus_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bv0, rs0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_wstrb", bus_wstrb, 4'h0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_bus_valid", bus_valid, 1'b0);

        // Minimum-latency read
        bv0 = bv_total; rs0 = rsp_total;
        issue(32'h0000_1000, 32'h0, 4'h0);
        chk("rd_bus_valid", bus_valid, 1'b1);
        chk("rd_bus_addr", bus_addr, 32'h0000_1000);
        finish_bus(0, 32'hDEAD_BEEF);
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp_err", rsp_err, 1'b0);
        chk("rd_req_ready_resp", req_ready, 1'b0);
        @(negedge clk);
        chk("rd_back_idle", req_ready, 1'b1);
        chk("rd_bv_cycles", bv_total - bv0, 1);

        // Write with five stall cycles
        bv0 = bv_total;
        issue(32'h0000_2000, 32'h1234_5678, 4'b0011);
        chk("wr_bus_wdata", bus_wdata, 32'h1234_5678);
        chk("wr_bus_wstrb", bus_wstrb, 4'b0011);
        finish_bus(5, 32'hFFFF_FFFF);
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rdata_held", rsp_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_bv_cycles", bv_total - bv0, 6);

        // Stray req_valid in BUSY/RESP and stray bus_ready in IDLE
        bv0 = bv_total; rs0 = rsp_total;
        req_valid = 1'b1; req_addr = 32'h0000_3000; req_wstrb = 4'h0;
        @(negedge clk);
        req_addr = 32'h0000_3004; bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus_ready = 1'b0;
        chk("pr_rsp_valid", rsp_valid, 1'b1);
        @(negedge clk);
        req_valid = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk);
        bus_ready = 1'b0;
        @(negedge clk);
        chk("pr_rsp_count", rsp_total - rs0, 1);
        chk("pr_bv_cycles", bv_total - bv0, 1);
        chk("pr_rdata", rsp_rdata, 32'hCAFE_F00D);
        chk("pr_bus_addr", bus_addr, 32'h0000_3000);

        // Reset in the second BUSY cycle
        rs0 = rsp_total;
        issue(32'h0000_4000, 32'h0, 4'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rs_bus_valid", bus_valid, 1'b0);
        chk("rs_req_ready", req_ready, 1'b1);
        chk("rs_rsp_valid", rsp_valid, 1'b0);
        chk("rs_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        chk("rs_no_rsp", rsp_total - rs0, 0);
        issue(32'h0000_5000, 32'h0, 4'h0);
        finish_bus(2, 32'h0BAD_F00D);
        chk("rs_rd_rsp_valid", rsp_valid, 1'b1);
        chk("rs_rd_rdata", rsp_rdata, 32'h0BAD_F00D);
        @(negedge clk);

`ifdef MEM_BUS_TIMEOUT_EN
        // Abort after TO stalled cycles
        bv0 = bv_total;
        issue(32'h0000_6000, 32'h0, 4'h0);
        repeat (TO) @(negedge clk);
        chk("to_rsp_valid", rsp_valid, 1'b1);
        chk("to_rsp_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        chk("to_bv_cycles", bv_total - bv0, TO);
        // bus_ready on the deciding cycle completes normally
        issue(32'h0000_6004, 32'h0, 4'h0);
        finish_bus(TO - 1, 32'h1111_2222);
        chk("tb_rsp_valid", rsp_valid, 1'b1);
        chk("tb_rsp_err", rsp_err, 1'b0);
        chk("tb_rdata", rsp_rdata, 32'h1111_2222);
        @(negedge clk);
`else
        // Without the abort feature a long stall just waits
        bv0 = bv_total;
        issue(32'h0000_6000, 32'h0, 4'h0);
        finish_bus(20, 32'h2222_3333);
        chk("lw_rsp_valid", rsp_valid, 1'b1);
        chk("lw_rsp_err", rsp_err, 1'b0);
        chk("lw_rdata", rsp_rdata, 32'h2222_3333);
        @(negedge clk);
        chk("lw_bv_cycles", bv_total - bv0, 21);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/mem_bus_bridge.md
MEM_BUS_BRIDGE -- requirements
Module: mem_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of BUSY cycles before an access is aborted (range 1..65535).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, meaning the datapath access request strobe.
REQ-005 SHALL have port req_ready, output, 1, meaning the bridge is idle and will accept a request.
REQ-006 SHALL have port req_addr, input, 32, meaning the access address (datapath mem_addr).
REQ-007 SHALL have port req_wdata, input, 32, meaning the store data (datapath mem_wdata).
REQ-008 SHALL have port req_wstrb, input, 4, meaning the byte enables; 4'b0000 marks a read.
REQ-009 SHALL have port rsp_valid, output, 1, meaning a one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 32, meaning the read data returned to the datapath (mem_rdata).
REQ-011 SHALL have port rsp_err, output, 1, meaning the access timed out; valid only with rsp_valid.
REQ-012 SHALL have ports bus_valid (output, 1), bus_addr (output, 32), bus_wdata (output, 32) and bus_wstrb (output, 4), meaning the system bus request.
REQ-013 SHALL have ports bus_ready (input, 1) and bus_rdata (input, 32), meaning the system bus completion and read data.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-015 In IDLE, SHALL drive req_ready=1; on req_valid=1 SHALL register req_addr, req_wdata and req_wstrb, clear the timeout counter and move to BUSY.
REQ-016 In BUSY, SHALL drive bus_valid=1 with bus_addr, bus_wdata and bus_wstrb taken from the registered values and held stable until exit.
REQ-017 In BUSY with bus_ready=1, SHALL capture bus_rdata into rsp_rdata when the registered wstrb is 0 (a write leaves rsp_rdata unchanged) and move to RESP.
REQ-018 In RESP, SHALL drive rsp_valid=1 for exactly one cycle, then return to IDLE.
REQ-019 Minimum latency: request accepted at edge N, bus_valid high in cycle N+1, bus_ready in N+1 gives rsp_valid in cycle N+2; the next request is accepted at edge N+3.
REQ-020 SHALL ignore req_valid outside IDLE and SHALL ignore bus_ready outside BUSY.
REQ-021 SHALL drive req_ready=0 and bus_valid=0 in RESP; there is no back-to-back overlap.
REQ-022 rsp_err SHALL be 0 on every response except a timeout abort (REQ-027).
REQ-023 rsp_rdata SHALL hold its last value between responses.

Reset
REQ-024 When reset=1 at an edge, SHALL enter IDLE and clear rsp_valid, rsp_err, bus_valid, the timeout counter and rsp_rdata (32'h0).
REQ-025 Reset SHALL take priority over all inputs; reset mid-BUSY drops bus_valid at the next edge and produces no rsp_valid for the aborted access.
REQ-026 After reset, bus_addr, bus_wdata and bus_wstrb SHALL read 0.

Configuration
REQ-027 With macro MEM_BUS_TIMEOUT_EN defined: SHALL increment a 16-bit counter each BUSY cycle without bus_ready; on reaching TIMEOUT_CYCLES SHALL drop bus_valid, go to RESP and pulse rsp_valid with rsp_err=1 and rsp_rdata=32'h0.
REQ-028 With MEM_BUS_TIMEOUT_EN defined: bus_ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally (rsp_err=0).
REQ-029 Without MEM_BUS_TIMEOUT_EN: no counter, BUSY waits indefinitely, rsp_err is tied to 0 and TIMEOUT_CYCLES is unused.

Verification
REQ-030 Read: req_valid with addr 32'h0000_1000 and wstrb 0; bus_ready in the first BUSY cycle with bus_rdata 32'hDEAD_BEEF -> rsp_valid two cycles after acceptance, rsp_rdata 32'hDEAD_BEEF, rsp_err 0.
REQ-031 Write: wstrb 4'b0011, wdata 32'h1234_5678, bus_ready held low for 5 cycles -> bus_valid high for 6 cycles with stable addr, wdata and wstrb; rsp_rdata unchanged.
REQ-032 Protocol: req_valid pulsed during BUSY and RESP, and bus_ready pulsed during IDLE -> no extra access and no extra response.
REQ-033 Timeout (MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4), bus_ready never asserted -> bus_valid high for 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata 32'h0; repeat with bus_ready in the 4th cycle -> rsp_err 0.
REQ-034 Reset asserted in the 2nd BUSY cycle -> next cycle bus_valid=0, req_ready=1, no rsp_valid; a following read completes normally.
